snowbro2_eeprom: RTL and testbench
==================================

Name: snowbro2_eeprom

Overview:
- Responder end of the main CPU's bit-banged serial EEPROM link (SCS/SCLK/SDI in, SDO out).
- Emulates a 93C46-class microwire EEPROM in x16 organisation: 64 words of 16 bits.
- Provides a second, parallel host port so the MiSTer side can load and save NVRAM contents, plus a dirty flag that triggers save.
- Sits in snowbro2_game beside snowbro2_cpu, with all ports on the 48 MHz game clock.

Parameters:
- AW, 6, word address width (64 words).
- DW, 16, data word width.
- BUSY_CYCLES, 64, CLK cycles SDO reads busy (0) after a program/erase commit.

Ports:
- CLK  in  1  game clock (48 MHz).
- RESET  in  1  synchronous reset, active-low.
- SCS  in  1  chip select from CPU latch, active-high.
- SCLK  in  1  serial clock from CPU latch; slow relative to CLK.
- SDI  in  1  serial data to the EEPROM.
- SDO  out  1  serial data / ready status to the CPU.
- HOST_ADDR  in  AW  host-port word address.
- HOST_DIN  in  DW  host-port write data.
- HOST_WE  in  1  host-port write strobe, one CLK.
- HOST_DOUT  out  DW  host-port read data, registered, 1-cycle latency.
- BUSY  out  1  high while the programming timer runs.
- DIRTY  out  1  set by any serial array modification.
- DIRTY_CLR  in  1  clears DIRTY.

Behaviour:
- Edge detection
  - SCLK and SCS are registered once. A rise is prev=0, cur=1; an SCS fall is prev=1, cur=0.
  - All serial actions take effect on the CLK after the detected edge.
- Reset (RESET=0 at a CLK edge)
  - state=IDLE, SDO=1, BUSY=0, DIRTY=0, write-enable latch WEN=0, HOST_DOUT=0.
  - The array is NOT cleared.
- Abort: SCS low in any state except BUSY returns to IDLE with nothing committed; SDO=1.
- IDLE: on an SCLK rise with SCS=1 and SDI=1 (start bit), go to OPC. SDI=0 rises are ignored (leading zeros).
- OPC: shift 2 bits, MSB first, then go to ADR.
- ADR: shift AW bits, MSB first. After the last address bit, decode:
  - 10 READ: load the shift register from array[addr]; SDO=0 (dummy bit); go to RD.
  - 01 WRITE: go to WR.
  - 11 ERASE: go to WAITCS; the pending word is FFFF.
  - 00, addr[5:4]=11 EWEN: WEN=1; go to IDLE-hold.
  - 00, addr[5:4]=00 EWDS: WEN=0; go to IDLE-hold.
  - 00, addr[5:4]=10 ERAL: go to WAITCS; all words become FFFF.
  - 00, addr[5:4]=01 WRAL: go to WR; the data goes to all words.
  - IDLE-hold ignores SCLK until SCS falls.
- RD
  - Each SCLK rise drives the next bit, D15 first.
  - After D0 the next rise outputs D15 of addr+1; the address wraps 63 to 0 (sequential read).
  - SDO stays valid until SCS falls.
- WR: shift exactly 16 data bits, MSB first, then go to WAITCS. Further rises are ignored.
- WAITCS: on the SCS fall, if WEN=1 commit the operation in that cycle, set DIRTY, load the busy counter and go to BUSY. If WEN=0, go to IDLE with no change.
- ERAL/WRAL commit sweeps 64 addresses, one per CLK. BUSY_CYCLES must be at least 64; the sweep finishes inside BUSY.
- BUSY
  - The counter decrements each CLK; BUSY=1.
  - When SCS=1, SDO=0 while the counter is non-zero and SDO=1 after it expires (ready poll).
  - At expiry go to IDLE.
  - SCLK and start bits are ignored in BUSY.
- Host port
  - HOST_DOUT = array[HOST_ADDR], registered.
  - HOST_WE writes array[HOST_ADDR]=HOST_DIN; it does not set DIRTY.
  - If a serial commit hits the same address in the same cycle, the serial write wins.
- DIRTY: a set and DIRTY_CLR in the same cycle leaves DIRTY=1 (set wins).
- Reset mid-operation: a commit already performed stays; an uncommitted WRITE is lost; an ERAL/WRAL sweep is truncated.

Test Plan:
- Host-load word 5=1234; serial READ addr 5 (bits 1,10,000101) -> SDO dummy 0, then 0001001000110100 on 16 rises.
- Serial WRITE addr 3, data ABCD, without EWEN -> after the SCS fall BUSY stays 0, word 3 unchanged, DIRTY=0.
- EWEN, then WRITE addr 3 = ABCD -> BUSY=1 for 64 CLKs; SCS high gives SDO=0 then 1; host read addr 3 = ABCD; DIRTY=1.
- EWEN, then ERAL -> all 64 host reads = FFFF; WRAL 5A5A -> all = 5A5A.
- Sequential READ starting at addr 63 for 32 data clocks -> word 63 followed by word 0.
- SCS dropped after 8 WRITE data bits -> no change. RESET=0 during RD -> SDO=1, state IDLE, array preserved.

Source files
------------

// File: rtl/snowbro2_eeprom.sv
// rtl/snowbro2_eeprom.sv - 93C46-style x16 microwire EEPROM responder with host NVRAM port
module snowbro2_eeprom #(
  parameter int AW          = 6,
  parameter int DW          = 16,
  parameter int BUSY_CYCLES = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SCS,
  input  logic          SCLK,
  input  logic          SDI,
  output logic          SDO,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_DIN,
  input  logic          HOST_WE,
  output logic [DW-1:0] HOST_DOUT,
  output logic          BUSY,
  output logic          DIRTY,
  input  logic          DIRTY_CLR
);

  localparam int NW = 1 << AW;
  localparam int CW = $clog2((DW > AW) ? DW : AW);
  localparam int BW = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADR, S_RD, S_WR, S_WAITCS, S_HOLD, S_BUSY
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_mem [NW];
  logic          r_sclk, r_sclk_p, r_scs, r_scs_p, r_sdi;
  logic [1:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_sr;
  logic [DW-1:0] r_data;
  logic          r_all;
  logic          r_wen;
  logic          r_sweep;
  logic [AW-1:0] r_sweep_addr;
  logic [BW-1:0] r_bcnt;

  logic          w_rise;
  logic          w_scs_fall;
  logic [AW-1:0] w_addr_next;
  logic [AW-1:0] w_addr_inc;
  logic          w_commit;
  logic          w_ser_we;
  logic [AW-1:0] w_ser_addr;

  assign w_rise      = r_sclk & ~r_sclk_p;
  assign w_scs_fall  = r_scs_p & ~r_scs;
  assign w_addr_next = {r_addr[AW-2:0], r_sdi};
  assign w_addr_inc  = r_addr + 1'b1;
  assign w_commit    = (r_state == S_WAITCS) && w_scs_fall && r_wen && RESET;
  // A bulk sweep starts at word 0 in the commit cycle and then walks 1..NW-1.
  assign w_ser_we    = (w_commit || r_sweep) && RESET;
  assign w_ser_addr  = r_sweep ? r_sweep_addr : (r_all ? '0 : r_addr);

  // Single register stage on the slow CPU-latch signals for edge detection
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sclk   <= 1'b0;
      r_sclk_p <= 1'b0;
      r_scs    <= 1'b0;
      r_scs_p  <= 1'b0;
      r_sdi    <= 1'b0;
    end else begin
      r_sclk   <= SCLK;
      r_sclk_p <= r_sclk;
      r_scs    <= SCS;
      r_scs_p  <= r_scs;
      r_sdi    <= SDI;
    end
  end

  // Word array: serial commits take priority over a host write to the same word
  always_ff @(posedge CLK) begin
    if (w_ser_we)
      r_mem[w_ser_addr] <= r_data;
    if (HOST_WE && !(w_ser_we && (w_ser_addr == HOST_ADDR)))
      r_mem[HOST_ADDR] <= HOST_DIN;
  end

  // Host read port, one cycle latency
  always_ff @(posedge CLK) begin
    if (!RESET) HOST_DOUT <= '0;
    else        HOST_DOUT <= r_mem[HOST_ADDR];
  end

  // Microwire protocol FSM, dirty flag and bulk-write sweep
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      SDO          <= 1'b1;
      BUSY         <= 1'b0;
      DIRTY        <= 1'b0;
      r_wen        <= 1'b0;
      r_sweep      <= 1'b0;
      r_sweep_addr <= '0;
      r_op         <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_sr         <= '0;
      r_data       <= '0;
      r_all        <= 1'b0;
      r_bcnt       <= '0;
    end else begin
      if (r_sweep) begin
        if (r_sweep_addr == {AW{1'b1}}) r_sweep <= 1'b0;
        else                             r_sweep_addr <= r_sweep_addr + 1'b1;
      end

      if (w_commit)       DIRTY <= 1'b1;
      else if (DIRTY_CLR) DIRTY <= 1'b0;

      if (!r_scs && (r_state != S_BUSY) && (r_state != S_WAITCS)) begin
        r_state <= S_IDLE;
        SDO     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            SDO <= 1'b1;
            if (w_rise && r_sdi) begin
              r_state <= S_OPC;
              r_cnt   <= '0;
            end
          end
          S_OPC: if (w_rise) begin
            r_op <= {r_op[0], r_sdi};
            if (r_cnt == CW'(1)) begin
              r_cnt   <= '0;
              r_state <= S_ADR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_ADR: if (w_rise) begin
            r_addr <= w_addr_next;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(AW - 1)) begin
              r_cnt <= '0;
              r_all <= 1'b0;
              case (r_op)
                2'b10: begin
                  r_sr    <= r_mem[w_addr_next];
                  SDO     <= 1'b0;
                  r_state <= S_RD;
                end
                2'b01: r_state <= S_WR;
                2'b11: begin
                  r_data  <= '1;
                  r_state <= S_WAITCS;
                end
                default: begin
                  case (w_addr_next[AW-1:AW-2])
                    2'b11: begin r_wen <= 1'b1; r_state <= S_HOLD; end
                    2'b00: begin r_wen <= 1'b0; r_state <= S_HOLD; end
                    2'b10: begin r_data <= '1; r_all <= 1'b1; r_state <= S_WAITCS; end
                    default: begin r_all <= 1'b1; r_state <= S_WR; end
                  endcase
                end
              endcase
            end
          end
          S_RD: if (w_rise) begin
            SDO <= r_sr[DW-1];
            if (r_cnt == CW'(DW - 1)) begin
              r_cnt  <= '0;
              r_addr <= w_addr_inc;
              r_sr   <= r_mem[w_addr_inc];
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_sr  <= {r_sr[DW-2:0], 1'b0};
            end
          end
          S_WR: if (w_rise) begin
            r_data <= {r_data[DW-2:0], r_sdi};
            if (r_cnt == CW'(DW - 1)) begin
              r_cnt   <= '0;
              r_state <= S_WAITCS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAITCS: begin
            if (w_scs_fall && r_wen) begin
              BUSY    <= 1'b1;
              r_bcnt  <= BW'(BUSY_CYCLES);
              r_state <= S_BUSY;
              if (r_all) begin
                r_sweep      <= 1'b1;
                r_sweep_addr <= AW'(1);
              end
            end else if (!r_scs) begin
              r_state <= S_IDLE;
            end
          end
          S_HOLD: SDO <= 1'b1;
          S_BUSY: begin
            if (r_bcnt > BW'(1)) begin
              r_bcnt <= r_bcnt - 1'b1;
              SDO    <= ~r_scs;
            end else begin
              r_bcnt  <= '0;
              BUSY    <= 1'b0;
              SDO     <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snowbro2_eeprom.sv
// tb/tb_snowbro2_eeprom.sv - randomized self-checking bench for snowbro2_eeprom
module tb_snowbro2_eeprom;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCS = 1'b0;
  logic        SCLK = 1'b0;
  logic        SDI = 1'b0;
  logic        SDO;
  logic [5:0]  HOST_ADDR = '0;
  logic [15:0] HOST_DIN = '0;
  logic        HOST_WE = 1'b0;
  logic [15:0] HOST_DOUT;
  logic        BUSY;
  logic        DIRTY;
  logic        DIRTY_CLR = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] m [64];
  bit          m_wen;
  bit          m_dirty;

  snowbro2_eeprom #(.AW(6), .DW(16), .BUSY_CYCLES(64)) dut (
    .CLK(CLK), .RESET(RESET), .SCS(SCS), .SCLK(SCLK), .SDI(SDI), .SDO(SDO),
    .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN), .HOST_WE(HOST_WE),
    .HOST_DOUT(HOST_DOUT), .BUSY(BUSY), .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR)
  );

  initial forever #10 CLK = ~CLK;

  task automatic wclk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sbit(input logic b, output logic so);
    SDI = b;
    wclk(3);
    SCLK = 1'b1;
    wclk(4);
    so = SDO;
    SCLK = 1'b0;
    wclk(3);
  endtask

  task automatic scmd(input logic [1:0] op, input logic [5:0] a, output logic so);
    logic d;
    int lead;
    SCS = 1'b1;
    wclk(2);
    lead = $urandom_range(0, 2);
    for (int i = 0; i < lead; i++) sbit(1'b0, d);
    sbit(1'b1, d);
    for (int i = 1; i >= 0; i--) sbit(op[i], d);
    for (int i = 5; i >= 0; i--) sbit(a[i], so);
  endtask

  task automatic sdata(input logic [15:0] d, input int n);
    logic so;
    for (int i = 15; i > 15 - n; i--) sbit(d[i], so);
  endtask

  task automatic send_ctl(input logic [1:0] sel);
    logic so;
    scmd(2'b00, {sel, 4'($urandom)}, so);
    SCS = 1'b0;
    wclk(4);
    if (sel == 2'b11) m_wen = 1'b1;
    if (sel == 2'b00) m_wen = 1'b0;
  endtask

  // Drop SCS after a program/erase command; check the busy window and poll.
  task automatic run_busy(input bit expect_commit, input string name);
    int len;
    int wt;
    wt = 0;
    SCS = 1'b0;
    while (BUSY !== 1'b1 && wt < 20) begin wclk(1); wt++; end
    checks++;
    if (!expect_commit) begin
      if (BUSY !== 1'b0) begin errors++; $display("FAIL %s_nobusy: BUSY=%b expected 0", name, BUSY); end
      wclk(2);
    end else if (BUSY !== 1'b1) begin
      errors++; $display("FAIL %s_busy_start: BUSY=%b expected 1 within 20 clk", name, BUSY);
    end else begin
      len = 0;
      SCS = 1'b1;
      while (BUSY === 1'b1 && len < 1000) begin
        wclk(1);
        len++;
        if (len == 20) begin
          checks++;
          if (SDO !== 1'b0) begin errors++; $display("FAIL %s_poll_busy: SDO=%b expected 0", name, SDO); end
        end
      end
      checks++;
      if (len != 64) begin errors++; $display("FAIL %s_busy_len: got %0d expected 64", name, len); end
      checks++;
      if (SDO !== 1'b1) begin errors++; $display("FAIL %s_poll_ready: SDO=%b expected 1", name, SDO); end
      SCS = 1'b0;
      wclk(3);
    end
  endtask

  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    HOST_ADDR = a;
    HOST_DIN  = d;
    HOST_WE   = 1'b1;
    wclk(1);
    HOST_WE   = 1'b0;
    m[a]      = d;
  endtask

  task automatic host_check(input logic [5:0] a, input string name);
    HOST_ADDR = a;
    wclk(2);
    checks++;
    if (HOST_DOUT !== m[a]) begin
      errors++;
      $display("FAIL %s_host[%0d]: got %h expected %h", name, a, HOST_DOUT, m[a]);
    end
  endtask

  task automatic serial_read(input logic [5:0] a, input int nwords, input string name);
    logic so;
    logic [15:0] got;
    logic [5:0] wa;
    scmd(2'b10, a, so);
    checks++;
    if (so !== 1'b0) begin errors++; $display("FAIL %s_dummy: SDO=%b expected 0", name, so); end
    for (int w = 0; w < nwords; w++) begin
      for (int b = 15; b >= 0; b--) begin
        sbit(1'($urandom), so);
        got[b] = so;
      end
      wa = a + 6'(w);
      checks++;
      if (got !== m[wa]) begin
        errors++;
        $display("FAIL %s_word%0d[%0d]: got %h expected %h", name, w, wa, got, m[wa]);
      end
    end
    SCS = 1'b0;
    wclk(4);
  endtask

  task automatic serial_write(input logic [5:0] a, input logic [15:0] d, input string name);
    logic so;
    scmd(2'b01, a, so);
    sdata(d, 16);
    run_busy(m_wen, name);
    if (m_wen) begin m[a] = d; m_dirty = 1'b1; end
  endtask

  task automatic check_dirty(input string name);
    checks++;
    if (DIRTY !== m_dirty) begin errors++; $display("FAIL %s_dirty: got %b expected %b", name, DIRTY, m_dirty); end
  endtask

  task automatic clear_dirty();
    DIRTY_CLR = 1'b1;
    wclk(1);
    DIRTY_CLR = 1'b0;
    m_dirty   = 1'b0;
    wclk(1);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    wclk(3);
    checks++;
    if (SDO !== 1'b1 || BUSY !== 1'b0 || DIRTY !== 1'b0 || HOST_DOUT !== 16'h0) begin
      errors++;
      $display("FAIL reset: SDO=%b BUSY=%b DIRTY=%b DOUT=%h expected 1 0 0 0000", SDO, BUSY, DIRTY, HOST_DOUT);
    end
    RESET = 1'b1;
    m_wen = 1'b0;
    m_dirty = 1'b0;
    wclk(2);
    for (int i = 0; i < 64; i++) host_write(6'(i), 16'($urandom));
  endtask

  task automatic test_read();
    host_write(6'd5, 16'h1234);
    serial_read(6'd5, 1, "read5");
    for (int i = 0; i < 4; i++) serial_read(6'($urandom), 1, "read_rand");
    check_dirty("read");
  endtask

  task automatic test_write_no_ewen();
    serial_write(6'd3, 16'hABCD, "wr_noewen");
    host_check(6'd3, "wr_noewen");
    check_dirty("wr_noewen");
  endtask

  task automatic test_write_ewen();
    send_ctl(2'b11);
    serial_write(6'd3, 16'hABCD, "wr_ewen");
    host_check(6'd3, "wr_ewen");
    check_dirty("wr_ewen");
    clear_dirty();
    check_dirty("dirty_clr");
  endtask

  task automatic test_eral_wral();
    logic so;
    scmd(2'b00, 6'b100000, so);
    run_busy(1'b1, "eral");
    for (int i = 0; i < 64; i++) m[i] = 16'hFFFF;
    m_dirty = 1'b1;
    for (int i = 0; i < 64; i++) host_check(6'(i), "eral");
    scmd(2'b00, 6'b010000, so);
    sdata(16'h5A5A, 16);
    run_busy(1'b1, "wral");
    for (int i = 0; i < 64; i++) m[i] = 16'h5A5A;
    for (int i = 0; i < 64; i++) host_check(6'(i), "wral");
    check_dirty("wral");
    clear_dirty();
  endtask

  task automatic test_seq_read();
    host_write(6'd63, 16'($urandom));
    host_write(6'd0, 16'($urandom));
    host_write(6'd1, 16'($urandom));
    serial_read(6'd63, 3, "seqread");
  endtask

  task automatic test_abort();
    logic so;
    logic [5:0] a;
    a = 6'($urandom);
    scmd(2'b01, a, so);
    sdata(16'($urandom), 8);
    SCS = 1'b0;
    wclk(20);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: BUSY=%b expected 0", BUSY); end
    host_check(a, "abort");
    check_dirty("abort");
  endtask

  task automatic test_random();
    logic so;
    logic [5:0] a;
    for (int it = 0; it < 24; it++) begin
      a = 6'($urandom);
      case ($urandom_range(0, 4))
        0: serial_read(a, 1, "rnd_read");
        1: begin serial_write(a, 16'($urandom), "rnd_write"); host_check(a, "rnd_write"); end
        2: begin
          scmd(2'b11, a, so);
          run_busy(m_wen, "rnd_erase");
          if (m_wen) begin m[a] = 16'hFFFF; m_dirty = 1'b1; end
          host_check(a, "rnd_erase");
        end
        3: send_ctl(2'b11);
        default: send_ctl(2'b00);
      endcase
    end
    check_dirty("random");
  endtask

  task automatic test_reset_mid_read();
    logic so;
    logic [5:0] a;
    a = 6'($urandom);
    scmd(2'b10, a, so);
    for (int i = 0; i < 5; i++) sbit(1'b0, so);
    RESET = 1'b0;
    wclk(2);
    checks++;
    if (SDO !== 1'b1 || BUSY !== 1'b0 || DIRTY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rd: SDO=%b BUSY=%b DIRTY=%b expected 1 0 0", SDO, BUSY, DIRTY);
    end
    RESET = 1'b1;
    SCS = 1'b0;
    m_wen = 1'b0;
    m_dirty = 1'b0;
    wclk(3);
    host_check(a, "reset_mid_rd");
    serial_read(a, 1, "after_reset");
    serial_write(a ^ 6'd1, 16'($urandom), "after_reset_wen");
    host_check(a ^ 6'd1, "after_reset_wen");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_no_ewen();
    test_write_ewen();
    test_eral_wral();
    test_seq_read();
    send_ctl(2'b11);
    test_abort();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
